// File: rtl/n2t_pkg.sv
// Shared definitions for the ram_512 block mover and its memory model.
//   ADDR_W / DATA_W : geometry of the ram_512 memory
//   mover_state_t   : block mover FSM states
//   MODE_COPY/FILL  : encoding of the mover's mode input
package n2t_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mover_state_t;

endpackage

// File: rtl/ram_512.sv
// 512-word RAM: combinational read of 'address', write of 'in' on the rising edge when 'load'.
//   clock   : write clock
//   in      : write data
//   address : read/write address
//   load    : write enable
//   out     : read data for 'address'
module ram_512
  import n2t_pkg::*;
(
  input  logic              clock,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];

  always_ff @(posedge clock) begin
    if (load) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram_block_mover.sv
// Block mover driving a ram_512 port: copies 'length' words from src_addr to dst_addr, or fills
// 'length' words at dst_addr with fill_value. Transfers proceed strictly upward one word at a
// time, so overlapping copies see their own earlier writes.
//   clock, reset            : system clock, synchronous active-high reset
//   start, mode             : one-cycle request (taken only in IDLE), 0 = copy / 1 = fill
//   src_addr, dst_addr      : base addresses, wrap modulo 2^ADDR_W
//   length, fill_value      : word count (clamped to 2^ADDR_W), fill word
//   busy, done              : busy in READ/WRITE, one-cycle completion pulse
//   mem_address/in/load/out : ram_512 port
module ram_block_mover #(
  parameter int unsigned ADDR_W = n2t_pkg::ADDR_W,
  parameter int unsigned DATA_W = n2t_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  import n2t_pkg::*;

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  mover_state_t      state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              mode_q, mode_d;
  logic              load_raw;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    load_raw    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          fill_d = fill_value;
          mode_d = mode;
          cnt_d  = (length > MaxLen) ? MaxLen : length;
          if (cnt_d == '0) begin
            state_d = DONE;
          end else if (mode == MODE_COPY) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_address = src_q;
        data_d      = mem_out;
        src_d       = src_q + ADDR_W'(1);
        state_d     = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_address = dst_q;
        load_raw    = 1'b1;
        mem_in      = (mode_q == MODE_FILL) ? fill_q : data_q;
        dst_d       = dst_q + ADDR_W'(1);
        cnt_d       = cnt_q - (ADDR_W + 1)'(1);
        if (cnt_d == '0) begin
          state_d = DONE;
        end else if (mode_q == MODE_FILL) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate the write strobe so no RAM write lands on an edge where reset is sampled.
  assign mem_load = load_raw & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fill_q  <= '0;
      mode_q  <= MODE_COPY;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_ram_block_mover.sv
module tb_ram_block_mover;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [9:0]  length;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [8:0]  mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  // Bench-side access to the RAM for preload and readback.
  logic        tb_sel;
  logic [8:0]  tb_addr;
  logic [15:0] tb_din;
  logic        tb_load;
  logic [8:0]  ram_addr;
  logic [15:0] ram_in;
  logic        ram_load;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign ram_addr = tb_sel ? tb_addr : mem_address;
  assign ram_in   = tb_sel ? tb_din  : mem_in;
  assign ram_load = tb_sel ? tb_load : mem_load;

  ram_block_mover u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .fill_value  (fill_value),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_out     (mem_out)
  );

  ram_512 u_ram (
    .clock   (clock),
    .in      (ram_in),
    .address (ram_addr),
    .load    (ram_load),
    .out     (mem_out)
  );

  typedef struct {
    string       name;
    logic        mode;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [9:0]  len;
    logic [15:0] fill;
    int          exp_done;
    int          exp_busy;
    int          exp_wr;
    logic [15:0] exp_pat;
  } op_t;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } mchk_t;

  op_t   ops[6];
  mchk_t mchk[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All helpers start and end aligned to a falling edge.
  task automatic ram_wr(input logic [8:0] a, input logic [15:0] d);
    tb_sel  = 1'b1;
    tb_addr = a;
    tb_din  = d;
    tb_load = 1'b1;
    @(negedge clock);
    tb_load = 1'b0;
  endtask

  task automatic ram_rd(input logic [8:0] a, output logic [15:0] d);
    tb_sel  = 1'b1;
    tb_addr = a;
    #1;
    d = mem_out;
    @(negedge clock);
  endtask

  task automatic ram_chk(input string name, input logic [8:0] a, input logic [15:0] exp);
    logic [15:0] d;
    ram_rd(a, d);
    check($sformatf("%s[%0d]", name, a), 32'(d), 32'(exp));
  endtask

  task automatic pulse_start(input logic m, input logic [8:0] s, input logic [8:0] dd,
                             input logic [9:0] l, input logic [15:0] f);
    tb_sel     = 1'b0;
    start      = 1'b1;
    mode       = m;
    src_addr   = s;
    dst_addr   = dd;
    length     = l;
    fill_value = f;
    @(negedge clock);
    start      = 1'b0;
    // Scramble inputs to show the in-flight transfer ignores them.
    mode       = ~m;
    src_addr   = s ^ 9'h155;
    dst_addr   = dd ^ 9'h0AA;
    length     = 10'd3;
    fill_value = ~f;
  endtask

  task automatic run_op(input logic m, input logic [8:0] s, input logic [8:0] dd,
                        input logic [9:0] l, input logic [15:0] f,
                        output int done_cyc, output int busy_n, output int wr_n,
                        output logic [15:0] pat);
    done_cyc = -1;
    busy_n   = 0;
    wr_n     = 0;
    pat      = '0;
    pulse_start(m, s, dd, l, f);
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      if (mem_load) begin
        wr_n++;
        if (cyc <= 16) pat[cyc-1] = 1'b1;
      end
      if (busy) busy_n++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int          dc, bn, wn, dones;
    logic [15:0] pat;

    ops[0] = '{"fill4",   1'b1, 9'd0,   9'd10,  10'd4, 16'hBEEF, 5, 4, 4, 16'h000F};
    ops[1] = '{"copy3",   1'b0, 9'd100, 9'd200, 10'd3, 16'h0000, 7, 6, 3, 16'h002A};
    ops[2] = '{"copywrap",1'b0, 9'd510, 9'd300, 10'd3, 16'h0000, 7, 6, 3, 16'h002A};
    ops[3] = '{"fillwrap",1'b1, 9'd0,   9'd511, 10'd2, 16'h1234, 3, 2, 2, 16'h0003};
    ops[4] = '{"overlap", 1'b0, 9'd50,  9'd51,  10'd3, 16'h0000, 7, 6, 3, 16'h002A};
    ops[5] = '{"len0",    1'b0, 9'd7,   9'd8,   10'd0, 16'hFFFF, 1, 0, 0, 16'h0000};

    mchk[0]  = '{9'd9,   16'h0000};
    mchk[1]  = '{9'd10,  16'hBEEF};
    mchk[2]  = '{9'd11,  16'hBEEF};
    mchk[3]  = '{9'd12,  16'hBEEF};
    mchk[4]  = '{9'd13,  16'hBEEF};
    mchk[5]  = '{9'd14,  16'h0000};
    mchk[6]  = '{9'd200, 16'h0001};
    mchk[7]  = '{9'd201, 16'h0002};
    mchk[8]  = '{9'd202, 16'h0003};
    mchk[9]  = '{9'd300, 16'h000A};
    mchk[10] = '{9'd301, 16'h000B};
    mchk[11] = '{9'd302, 16'h000C};
    mchk[12] = '{9'd511, 16'h1234};
    mchk[13] = '{9'd0,   16'h1234};
    mchk[14] = '{9'd1,   16'h0000};
    mchk[15] = '{9'd51,  16'h0007};
    mchk[16] = '{9'd53,  16'h0007};
    mchk[17] = '{9'd54,  16'h0000};

    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0;
    tb_sel = 1'b1; tb_addr = '0; tb_din = '0; tb_load = 1'b0;
    @(negedge clock);

    // Zero the RAM while reset is held, then preload the sources.
    for (int i = 0; i < 512; i++) ram_wr(9'(i), 16'h0000);
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_done",     32'(done),        32'd0);
    check("rst_mem_load", 32'(mem_load),    32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_in",   32'(mem_in),      32'd0);
    reset = 1'b0;
    ram_wr(9'd100, 16'd1); ram_wr(9'd101, 16'd2); ram_wr(9'd102, 16'd3);
    ram_wr(9'd510, 16'hA); ram_wr(9'd511, 16'hB); ram_wr(9'd0, 16'hC);
    ram_wr(9'd50, 16'd7);

    for (int i = 0; i < 6; i++) begin
      run_op(ops[i].mode, ops[i].src, ops[i].dst, ops[i].len, ops[i].fill, dc, bn, wn, pat);
      check({ops[i].name, "_done_cycle"}, 32'(dc),  32'(ops[i].exp_done));
      check({ops[i].name, "_busy_cycles"}, 32'(bn), 32'(ops[i].exp_busy));
      check({ops[i].name, "_writes"},     32'(wn),  32'(ops[i].exp_wr));
      check({ops[i].name, "_load_pat"},   32'(pat), 32'(ops[i].exp_pat));
    end
    for (int i = 0; i < 18; i++) ram_chk("ram", mchk[i].a, mchk[i].d);

    // start while busy (cycle 2) and during DONE (cycle 6) must both be ignored.
    wn = 0; dones = 0; dc = -1;
    pulse_start(1'b1, 9'd0, 9'd20, 10'd5, 16'h0F0F);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      start = (cyc == 2 || cyc == 6);
      if (mem_load) wn++;
      if (done) begin
        dones++;
        dc = cyc;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("collide_writes",     32'(wn),    32'd5);
    check("collide_dones",      32'(dones), 32'd1);
    check("collide_done_cycle", 32'(dc),    32'd6);
    check("collide_idle_busy",  32'(busy),  32'd0);
    ram_chk("collide", 9'd24, 16'h0F0F);
    ram_chk("collide", 9'd25, 16'h0000);

    // Reset during cycle 5 of an 8-word copy: only two words land.
    for (int i = 220; i < 224; i++) ram_wr(9'(i), 16'hDEAD);
    pulse_start(1'b0, 9'd100, 9'd220, 10'd8, 16'h0000);
    for (int cyc = 1; cyc < 5; cyc++) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_load", 32'(mem_load), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy),        32'd0);
    check("rst_mid_addr", 32'(mem_address), 32'd0);
    dones = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (done || busy) dones++;
      @(negedge clock);
    end
    check("rst_mid_no_done", 32'(dones), 32'd0);

    // Reset on a WRITE cycle must suppress that write.
    pulse_start(1'b1, 9'd0, 9'd230, 10'd3, 16'h7777);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_write_gated", 32'(mem_load), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check("rst_write_busy", 32'(busy), 32'd0);

    run_op(1'b0, 9'd100, 9'd240, 10'd2, 16'h0000, dc, bn, wn, pat);
    check("after_rst_done_cycle", 32'(dc), 32'd5);
    check("after_rst_writes",     32'(wn), 32'd2);
    ram_chk("rst_mid", 9'd220, 16'd1);
    ram_chk("rst_mid", 9'd221, 16'd2);
    ram_chk("rst_mid", 9'd222, 16'hDEAD);
    ram_chk("rst_wr",  9'd230, 16'h7777);
    ram_chk("rst_wr",  9'd231, 16'h0000);
    ram_chk("after",   9'd240, 16'd1);
    ram_chk("after",   9'd241, 16'd2);

    // Over-long length clamps to the full 512 words, wrapping once.
    run_op(1'b1, 9'd0, 9'd5, 10'd700, 16'h5A5A, dc, bn, wn, pat);
    check("clamp_done_cycle", 32'(dc), 32'd513);
    check("clamp_writes",     32'(wn), 32'd512);
    ram_chk("clamp", 9'd4,   16'h5A5A);
    ram_chk("clamp", 9'd5,   16'h5A5A);
    ram_chk("clamp", 9'd300, 16'h5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
